// File: rtl/riscv_register_file_mp.sv
// riscv_register_file_mp: flip-flop integer register file with N_READ
// combinational read ports, N_WRITE write ports, optional write-to-read bypass
// and a per-register busy scoreboard (set at issue, cleared at write-back).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   raddr_i / rdata_o        packed read addresses / read data, one slice per port
//   rbusy_o                  busy flag of the addressed register, per read port
//   waddr_i, wdata_i, we_i   packed write addresses / data / enables
//   rsv_i, rsv_addr_i        reserve a destination register (mark busy)
//   flush_i                  clear every busy bit
//   nbusy_o                  registered count of busy registers
module riscv_register_file_mp #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_READ     = 3,
  parameter int unsigned N_WRITE    = 2,
  parameter int unsigned BYPASS     = 0,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_READ*ADDR_WIDTH-1:0]   raddr_i,
  output logic [N_READ*DATA_WIDTH-1:0]   rdata_o,
  output logic [N_READ-1:0]              rbusy_o,
  input  logic [N_WRITE*ADDR_WIDTH-1:0]  waddr_i,
  input  logic [N_WRITE*DATA_WIDTH-1:0]  wdata_i,
  input  logic [N_WRITE-1:0]             we_i,
  input  logic                           rsv_i,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
  input  logic                           flush_i,
  output logic [ADDR_WIDTH:0]            nbusy_o
);

  localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W     = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]      nbusy_q, nbusy_d;

  logic [ADDR_WIDTH-1:0] raddr [N_READ];
  logic [ADDR_WIDTH-1:0] waddr [N_WRITE];
  logic [DATA_WIDTH-1:0] wdata [N_WRITE];

  // Unpack the flat port buses
  for (genvar p = 0; p < N_READ; p++) begin : g_rd_unpack
    assign raddr[p] = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
  end
  for (genvar w = 0; w < N_WRITE; w++) begin : g_wr_unpack
    assign waddr[w] = waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata[w] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
  end

  // Register write: ascending port loop so the highest index wins on collisions
  always_comb begin
    mem_d = mem_q;
    for (int unsigned w = 0; w < N_WRITE; w++) begin
      if (we_i[w]) begin
        mem_d[waddr[w]] = wdata[w];
      end
    end
    if (ZERO_REG != 0) begin
      mem_d[0] = '0;
    end
  end

  // Scoreboard next state: applied lowest to highest priority so later steps override
  always_comb begin
    busy_d = busy_q;
    for (int unsigned w = 0; w < N_WRITE; w++) begin
      if (we_i[w]) begin
        busy_d[waddr[w]] = 1'b0;
      end
    end
    if (rsv_i) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    nbusy_d = '0;
    for (int unsigned r = 0; r < NUM_WORDS; r++) begin
      nbusy_d = nbusy_d + CNT_W'(busy_d[r]);
    end
  end

  // Combinational read with optional same-cycle forwarding; reset and r0 force zero
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int unsigned p = 0; p < N_READ; p++) begin
      rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[p]];
      rbusy_o[p]                          = busy_q[raddr[p]];
      if (BYPASS != 0) begin
        for (int unsigned w = 0; w < N_WRITE; w++) begin
          if (we_i[w] && (waddr[w] == raddr[p])) begin
            rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wdata[w];
            rbusy_o[p]                          = 1'b0;
          end
        end
      end
      if (rst || ((ZERO_REG != 0) && (raddr[p] == '0))) begin
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        rbusy_o[p]                          = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_WORDS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q  <= '0;
      nbusy_q <= '0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      nbusy_q <= nbusy_d;
    end
  end

  assign nbusy_o = nbusy_q;

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// tb_riscv_register_file_mp: scoreboard bench for riscv_register_file_mp.
// Two instances share stimulus: dut_a (BYPASS=0) and dut_b (BYPASS=1).
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_riscv_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic        flush;

  logic [95:0] rdata_a, rdata_b;
  logic [2:0]  rbusy_a, rbusy_b;
  logic [5:0]  nbusy_a, nbusy_b;

  typedef struct {
    string       name;
    bit          byp;
    int          kind;   // 0 rdata, 1 rbusy, 2 nbusy
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  riscv_register_file_mp #(.BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .flush_i(flush), .nbusy_o(nbusy_a)
  );

  riscv_register_file_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .flush_i(flush), .nbusy_o(nbusy_b)
  );

  function automatic logic [31:0] actual(input exp_t e);
    logic [31:0] v;
    case (e.kind)
      0:       v = e.byp ? rdata_b[e.port*32 +: 32] : rdata_a[e.port*32 +: 32];
      1:       v = {31'b0, (e.byp ? rbusy_b[e.port] : rbusy_a[e.port])};
      default: v = {26'b0, (e.byp ? nbusy_b : nbusy_a)};
    endcase
    return v;
  endfunction

  // Monitor: outputs are presented every cycle; check everything queued for it
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = actual(mon_e);
      n_tests++;
      if (mon_act !== mon_e.exp) begin
        n_fail++;
        $display("FAIL %s (%s port %0d): got %h expected %h", mon_e.name,
                 mon_e.byp ? "bypass" : "nobypass", mon_e.port, mon_act, mon_e.exp);
      end
    end
  end

  task automatic push(input string n, input bit byp, input int kind, input int p,
                      input logic [31:0] v);
    exp_t e;
    e.name = n; e.byp = byp; e.kind = kind; e.port = p; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_rd(input string n, input bit byp, input int p, input logic [31:0] v);
    push(n, byp, 0, p, v);
  endtask

  task automatic exp_bz(input string n, input bit byp, input int p, input logic v);
    push(n, byp, 1, p, {31'b0, v});
  endtask

  task automatic exp_nb(input string n, input bit byp, input int v);
    push(n, byp, 2, 0, 32'(v));
  endtask

  // Advance one cycle and return write/reserve/flush controls to idle
  task automatic step();
    @(posedge clk);
    #1;
    we    = '0;
    rsv   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    raddr[p*5 +: 5] = a;
  endtask

  task automatic wr(input int w, input logic [4:0] a, input logic [31:0] d);
    we[w]             = 1'b1;
    waddr[w*5 +: 5]   = a;
    wdata[w*32 +: 32] = d;
  endtask

  task automatic reserve(input logic [4:0] a);
    rsv      = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
    rsv = 1'b0; rsv_addr = '0; flush = 1'b0;

    // Reset state
    step();
    exp_rd("rst_rdata", 1'b0, 0, 32'h0);
    exp_nb("rst_nbusy", 1'b0, 0);
    exp_bz("rst_rbusy", 1'b0, 0, 1'b0);
    step();
    rst = 1'b0;

    // Single write, visible next cycle on all ports; r0 reads 0
    step();
    wr(0, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5); set_rd(1, 5'd5); set_rd(2, 5'd5);
    exp_rd("wr5_same_cycle", 1'b0, 0, 32'h0);
    exp_rd("wr5_bypass", 1'b1, 0, 32'hDEADBEEF);
    step();
    set_rd(2, 5'd0);
    exp_rd("rd5_p0", 1'b0, 0, 32'hDEADBEEF);
    exp_rd("rd5_p1", 1'b0, 1, 32'hDEADBEEF);
    exp_rd("rd0_p2", 1'b0, 2, 32'h0);
    exp_rd("rd0_p2", 1'b1, 2, 32'h0);

    // Same-address collision: highest port wins
    step();
    wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22);
    set_rd(0, 5'd3);
    exp_rd("coll_same_cycle", 1'b0, 0, 32'h0);
    exp_rd("coll_bypass", 1'b1, 0, 32'h22);
    step();
    exp_rd("coll_next", 1'b0, 0, 32'h22);
    exp_rd("coll_next", 1'b1, 0, 32'h22);

    // Bypass vs registered read of r7
    step();
    wr(0, 5'd7, 32'hA5A5A5A5);
    set_rd(0, 5'd7);
    exp_rd("r7_old", 1'b0, 0, 32'h0);
    exp_rd("r7_fwd", 1'b1, 0, 32'hA5A5A5A5);
    step();
    exp_rd("r7_next", 1'b0, 0, 32'hA5A5A5A5);

    // Writes to r0 ignored and never forwarded
    step();
    wr(0, 5'd0, 32'hFFFFFFFF);
    set_rd(0, 5'd0);
    exp_rd("r0_no_fwd", 1'b1, 0, 32'h0);
    step();
    exp_rd("r0_no_write", 1'b0, 0, 32'h0);

    // Reservation and write-back of r9
    step();
    reserve(5'd9);
    set_rd(0, 5'd9);
    exp_bz("rsv9_same_cycle", 1'b0, 0, 1'b0);
    step();
    exp_bz("rsv9_busy", 1'b0, 0, 1'b1);
    exp_nb("rsv9_nbusy", 1'b0, 1);
    step();
    wr(0, 5'd9, 32'h99);
    exp_bz("wb9_nobyp_busy", 1'b0, 0, 1'b1);
    exp_bz("wb9_byp_busy", 1'b1, 0, 1'b0);
    exp_nb("wb9_nbusy_pre", 1'b0, 1);
    step();
    exp_bz("wb9_clear", 1'b0, 0, 1'b0);
    exp_nb("wb9_nbusy", 1'b0, 0);
    exp_rd("wb9_data", 1'b0, 0, 32'h99);
    step();
    reserve(5'd9); wr(1, 5'd9, 32'h9A);
    step();
    exp_bz("rsv_beats_wb", 1'b0, 0, 1'b1);
    exp_nb("rsv_beats_wb_cnt", 1'b0, 1);
    exp_rd("rsv_beats_wb_data", 1'b0, 0, 32'h9A);
    step();
    flush = 1'b1;
    step();
    exp_nb("flush_cnt", 1'b0, 0);
    exp_bz("flush_busy", 1'b0, 0, 1'b0);

    // Fill the scoreboard, r0 ignored, flush beats reservation
    for (int r = 1; r < 32; r++) begin
      step();
      reserve(5'(r));
    end
    step();
    reserve(5'd0);
    set_rd(0, 5'd0); set_rd(1, 5'd31);
    exp_nb("fill_31", 1'b0, 31);
    exp_nb("fill_31", 1'b1, 31);
    step();
    flush = 1'b1; reserve(5'd4);
    exp_nb("rsv_r0_ignored", 1'b0, 31);
    exp_bz("r0_never_busy", 1'b0, 0, 1'b0);
    exp_bz("r31_busy", 1'b0, 1, 1'b1);
    step();
    set_rd(0, 5'd4);
    exp_nb("flush_rsv_cnt", 1'b0, 0);
    exp_bz("flush_rsv_r4", 1'b0, 0, 1'b0);

    // Mid-run asynchronous reset
    step();
    reserve(5'd10); wr(0, 5'd2, 32'h55);
    step();
    reserve(5'd11);
    step();
    reserve(5'd12);
    step();
    reserve(5'd13);
    step();
    set_rd(0, 5'd2); set_rd(1, 5'd10);
    exp_nb("pre_rst_cnt", 1'b0, 4);
    exp_rd("pre_rst_r2", 1'b0, 0, 32'h55);
    exp_bz("pre_rst_r10", 1'b0, 1, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    wr(0, 5'd2, 32'h77);
    exp_rd("rst_r2_a", 1'b0, 0, 32'h0);
    exp_rd("rst_r2_b", 1'b1, 0, 32'h0);
    exp_bz("rst_r10_busy", 1'b0, 1, 1'b0);
    exp_nb("rst_cnt_a", 1'b0, 0);
    exp_nb("rst_cnt_b", 1'b1, 0);
    step();
    rst = 1'b0;
    set_rd(1, 5'd5);
    exp_rd("post_rst_r2", 1'b0, 0, 32'h0);
    exp_rd("post_rst_r5", 1'b0, 1, 32'h0);
    exp_bz("post_rst_r10", 1'b0, 1, 1'b0);
    exp_nb("post_rst_cnt", 1'b0, 0);

    step();
    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
